// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the N-lane hazard unit: forward-select field layout,
// performance-event indices and the forward-select encoder.
package hazard_pkg;

    localparam int unsigned FWD_W_BIT    = 0;
    localparam int unsigned FWD_M_BIT    = 1;
    localparam int unsigned FWD_LANE_LSB = 2;
    localparam int unsigned FWD_MAX_W    = 4;
    localparam int unsigned NUM_EV       = 5;

    localparam logic [4:0] REG_A0 = 5'd10;

    typedef enum logic [2:0] {
        EvLoad  = 3'd0,
        EvEcall = 3'd1,
        EvLong  = 3'd2,
        EvMiss  = 3'd3,
        EvFlush = 3'd4
    } hazard_ev_e;

    // Callers keep the low LW+2 bits; the lane field is sized for up to four lanes.
    function automatic logic [FWD_MAX_W-1:0] fwd_enc(input logic [1:0] lane, input logic m,
                                                     input logic w);
        logic [FWD_MAX_W-1:0] enc;
        enc                          = '0;
        enc[FWD_LANE_LSB +: 2]       = lane;
        enc[FWD_M_BIT]               = m;
        enc[FWD_W_BIT]               = w;
        return enc;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for long-latency results; a register is busy while its
// counter is nonzero.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = 4,
    parameter int unsigned LANES = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     stall_i,
    input  logic [LANES-1:0]         long_i,
    input  logic [LANES*5-1:0]       rd_i,
    input  logic [LANES*LAT_W-1:0]   lat_i,
    input  logic [LANES-1:0]         kill_i,
    output logic [NREG-1:0]          busy_o
);

    logic [LAT_W-1:0] cnt_q [1:NREG-1];
    logic [LAT_W-1:0] cnt_d [1:NREG-1];

    always_comb begin
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (!stall_i) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - LAT_W'(1);
                end
                // Ascending lane order lets the youngest lane's latency win.
                for (int j = 0; j < LANES; j++) begin
                    if (long_i[j] && !kill_i[j] && rd_i[j*5 +: 5] == 5'(r)
                        && lat_i[j*LAT_W +: LAT_W] != '0) begin
                        cnt_d[r] = lat_i[j*LAT_W +: LAT_W];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    always_comb begin
        busy_o    = '0;
        for (int r = 1; r < NREG; r++) begin
            busy_o[r] = (cnt_q[r] != '0);
        end
    end

endmodule

// File: rtl/hazard_unit_n.sv
// N-lane hazard unit: operand forwarding, stall/flush generation, long-op scoreboard and
// saturating hazard-event counters.
module hazard_unit_n
    import hazard_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned NREG  = 32,
    parameter int unsigned LAT_W = 4,
    parameter int unsigned CNT_W = 32,
    localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1,
    localparam int unsigned FWD_W = LW + 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enableD,
    input  logic [LANES*5-1:0]       Rs1D,
    input  logic [LANES*5-1:0]       Rs2D,
    input  logic [LANES*5-1:0]       Rs1E,
    input  logic [LANES*5-1:0]       Rs2E,
    input  logic [LANES*5-1:0]       RdE,
    input  logic [LANES-1:0]         LoadE,
    input  logic [LANES-1:0]         EcallE,
    input  logic [LANES-1:0]         EcallM,
    input  logic [LANES-1:0]         LongE,
    input  logic [LANES*LAT_W-1:0]   LongLatE,
    input  logic [LANES*5-1:0]       RdM,
    input  logic [LANES*5-1:0]       RdW,
    input  logic [LANES-1:0]         RegWriteM,
    input  logic [LANES-1:0]         RegWriteW,
    input  logic [LANES-1:0]         PCSrcE,
    input  logic [LANES-1:0]         StallMiss,
    output logic [LANES*FWD_W-1:0]   ForwardAE,
    output logic [LANES*FWD_W-1:0]   ForwardBE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     StallW,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic [CNT_W-1:0]         CntLoad,
    output logic [CNT_W-1:0]         CntEcall,
    output logic [CNT_W-1:0]         CntLong,
    output logic [CNT_W-1:0]         CntMiss,
    output logic [CNT_W-1:0]         CntFlush
);

    logic             stall;
    logic             load_haz;
    logic             ecall_haz;
    logic             long_haz;
    logic             dec_haz;
    logic [LANES-1:0] lane_kill;
    logic [NREG-1:0]  busy;
    logic [31:0]      busy_ext;
    logic [NUM_EV-1:0] ev;

    // W is scanned before M so an M match overrides; higher lanes override lower ones.
    always_comb begin : fwd_comb
        logic [FWD_MAX_W-1:0] sel_a;
        logic [FWD_MAX_W-1:0] sel_b;
        logic [4:0]           ra;
        logic [4:0]           rb;
        ForwardAE = '0;
        ForwardBE = '0;
        for (int i = 0; i < LANES; i++) begin
            ra    = Rs1E[i*5 +: 5];
            rb    = Rs2E[i*5 +: 5];
            sel_a = '0;
            sel_b = '0;
            for (int j = 0; j < LANES; j++) begin
                if (RegWriteW[j] && ra != '0 && RdW[j*5 +: 5] == ra) sel_a = fwd_enc(2'(j), 1'b0, 1'b1);
                if (RegWriteW[j] && rb != '0 && RdW[j*5 +: 5] == rb) sel_b = fwd_enc(2'(j), 1'b0, 1'b1);
            end
            for (int j = 0; j < LANES; j++) begin
                if (RegWriteM[j] && ra != '0 && RdM[j*5 +: 5] == ra) sel_a = fwd_enc(2'(j), 1'b1, 1'b0);
                if (RegWriteM[j] && rb != '0 && RdM[j*5 +: 5] == rb) sel_b = fwd_enc(2'(j), 1'b1, 1'b0);
            end
            ForwardAE[i*FWD_W +: FWD_W] = sel_a[FWD_W-1:0];
            ForwardBE[i*FWD_W +: FWD_W] = sel_b[FWD_W-1:0];
        end
    end

    always_comb begin
        busy_ext          = '0;
        busy_ext[NREG-1:0] = busy;
    end

    always_comb begin : haz_comb
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] rd;
        logic       a0_read;
        load_haz = 1'b0;
        long_haz = 1'b0;
        a0_read  = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            s1 = Rs1D[k*5 +: 5];
            s2 = Rs2D[k*5 +: 5];
            if (s1 == REG_A0 || s2 == REG_A0) a0_read = 1'b1;
            if ((s1 != '0 && busy_ext[s1]) || (s2 != '0 && busy_ext[s2])) long_haz = 1'b1;
            for (int j = 0; j < LANES; j++) begin
                rd = RdE[j*5 +: 5];
                if (LoadE[j] && rd != '0 && (s1 == rd || s2 == rd)) load_haz = 1'b1;
            end
        end
        load_haz  = load_haz & enableD;
        long_haz  = long_haz & enableD;
        ecall_haz = enableD & (|(EcallE | EcallM)) & a0_read;
    end

    // A taken branch in lane i squashes every younger lane in E.
    always_comb begin
        lane_kill = '0;
        for (int j = 1; j < LANES; j++) begin
            lane_kill[j] = lane_kill[j-1] | PCSrcE[j-1];
        end
    end

    assign stall   = |StallMiss;
    assign dec_haz = load_haz | ecall_haz | long_haz;
    assign StallF  = stall | dec_haz;
    assign StallD  = stall | dec_haz;
    assign StallE  = stall;
    assign StallM  = stall;
    assign StallW  = stall;
    assign FlushD  = !stall & (|PCSrcE);
    assign FlushE  = !stall & ((|PCSrcE) | dec_haz);

    hazard_scoreboard #(
        .NREG  (NREG),
        .LAT_W (LAT_W),
        .LANES (LANES)
    ) u_scoreboard (
        .clk_i   (clk),
        .rst_ni  (reset),
        .stall_i (stall),
        .long_i  (LongE),
        .rd_i    (RdE),
        .lat_i   (LongLatE),
        .kill_i  (lane_kill),
        .busy_o  (busy)
    );

    always_comb begin
        ev          = '0;
        ev[EvLoad]  = load_haz;
        ev[EvEcall] = ecall_haz;
        ev[EvLong]  = long_haz;
        ev[EvMiss]  = stall;
        ev[EvFlush] = FlushD;
    end

    logic [CNT_W-1:0] perf_q [NUM_EV];

    for (genvar e = 0; e < NUM_EV; e++) begin : g_perf
        logic [CNT_W-1:0] perf_d;
        always_comb begin
            perf_d = perf_q[e];
            if (ev[e] && perf_q[e] != '1) perf_d = perf_q[e] + CNT_W'(1);
        end
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) perf_q[e] <= '0;
            else        perf_q[e] <= perf_d;
        end
    end

    assign CntLoad  = perf_q[EvLoad];
    assign CntEcall = perf_q[EvEcall];
    assign CntLong  = perf_q[EvLong];
    assign CntMiss  = perf_q[EvMiss];
    assign CntFlush = perf_q[EvFlush];

endmodule

// File: tb/tb_hazard_unit_n.sv
// Directed self-checking bench for hazard_unit_n (LANES=2); a second instance with 3-bit
// counters shares the stimulus to exercise counter saturation.
module tb_hazard_unit_n;

    localparam int unsigned LANES = 2;
    localparam int unsigned LAT_W = 4;
    localparam int unsigned CNT_W = 32;
    localparam int unsigned FWD_W = 3;

    logic                   clk;
    logic                   reset;
    logic                   enableD;
    logic [LANES*5-1:0]     Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [LANES-1:0]       LoadE, EcallE, EcallM, LongE, RegWriteM, RegWriteW, PCSrcE, StallMiss;
    logic [LANES*LAT_W-1:0] LongLatE;
    logic [LANES*FWD_W-1:0] ForwardAE, ForwardBE, s_fwd_a, s_fwd_b;
    logic                   StallF, StallD, StallE, StallM, StallW, FlushD, FlushE;
    logic                   s_sf, s_sd, s_se, s_sm, s_sw, s_fd, s_fe;
    logic [CNT_W-1:0]       CntLoad, CntEcall, CntLong, CntMiss, CntFlush;
    logic [2:0]             s_cl, s_ce, s_clg, s_cm, s_cf;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hazard_unit_n #(.LANES(LANES), .NREG(32), .LAT_W(LAT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enableD(enableD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE), .EcallE(EcallE),
        .EcallM(EcallM), .LongE(LongE), .LongLatE(LongLatE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .StallMiss(StallMiss), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .StallW(StallW), .FlushD(FlushD), .FlushE(FlushE), .CntLoad(CntLoad),
        .CntEcall(CntEcall), .CntLong(CntLong), .CntMiss(CntMiss), .CntFlush(CntFlush)
    );

    hazard_unit_n #(.LANES(LANES), .NREG(32), .LAT_W(LAT_W), .CNT_W(3)) dut_small (
        .clk(clk), .reset(reset), .enableD(enableD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .LoadE(LoadE), .EcallE(EcallE),
        .EcallM(EcallM), .LongE(LongE), .LongLatE(LongLatE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
        .StallMiss(StallMiss), .ForwardAE(s_fwd_a), .ForwardBE(s_fwd_b),
        .StallF(s_sf), .StallD(s_sd), .StallE(s_se), .StallM(s_sm),
        .StallW(s_sw), .FlushD(s_fd), .FlushE(s_fe), .CntLoad(s_cl),
        .CntEcall(s_ce), .CntLong(s_clg), .CntMiss(s_cm), .CntFlush(s_cf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        enableD = 0; Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
        LoadE = '0; EcallE = '0; EcallM = '0; LongE = '0; LongLatE = '0;
        RegWriteM = '0; RegWriteW = '0; PCSrcE = '0; StallMiss = '0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        StallMiss = 2'b01;
        repeat (2) @(negedge clk);
        StallMiss = 2'b00;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if (CntMiss !== 32'd0) $display("FAIL reset_cntmiss got %0d want 0", CntMiss);
        else pass_cnt++;
        total_cnt++;
        if ({CntLoad, CntEcall, CntLong, CntFlush} !== '0)
            $display("FAIL reset_counters got %0h want 0", {CntLoad, CntEcall, CntLong, CntFlush});
        else pass_cnt++;
        total_cnt++;
        if ({StallF, StallD, StallE, FlushD, FlushE} !== 5'b0)
            $display("FAIL reset_ctrl got %b want 00000", {StallF, StallD, StallE, FlushD, FlushE});
        else pass_cnt++;
        total_cnt++;
        if ({ForwardAE, ForwardBE} !== '0)
            $display("FAIL reset_fwd got %h want 0", {ForwardAE, ForwardBE});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_forward();
        apply_reset();
        Rs1E[4:0] = 5'd5; RdM[9:5] = 5'd5; RdW[4:0] = 5'd5;
        RegWriteM = 2'b10; RegWriteW = 2'b01;
        #1;
        total_cnt++;
        if (ForwardAE[2:0] !== 3'b110) $display("FAIL fwd_m_beats_w got %b want 110", ForwardAE[2:0]);
        else pass_cnt++;
        RegWriteM = 2'b00;
        #1;
        total_cnt++;
        if (ForwardAE[2:0] !== 3'b001) $display("FAIL fwd_w_lane0 got %b want 001", ForwardAE[2:0]);
        else pass_cnt++;
        RdW[9:5] = 5'd5; RegWriteW = 2'b11;
        #1;
        total_cnt++;
        if (ForwardAE[2:0] !== 3'b101) $display("FAIL fwd_w_youngest got %b want 101", ForwardAE[2:0]);
        else pass_cnt++;
        RdM[4:0] = 5'd5; RdM[9:5] = 5'd6; RegWriteM = 2'b11;
        Rs1E[9:5] = 5'd6;
        #1;
        total_cnt++;
        if (ForwardAE !== 6'b110_010) $display("FAIL fwd_m_both_lanes got %b want 110010", ForwardAE);
        else pass_cnt++;
        Rs2E = '0; RdM[4:0] = 5'd0; RdW = '0;
        #1;
        total_cnt++;
        if (ForwardBE !== 6'b000_000) $display("FAIL fwd_x0 got %b want 000000", ForwardBE);
        else pass_cnt++;
    endtask

    task automatic test_load();
        apply_reset();
        LoadE = 2'b10; RdE[9:5] = 5'd7; Rs2D[4:0] = 5'd7; enableD = 1;
        #1;
        total_cnt++;
        if ({StallF, StallD, FlushE} !== 3'b111)
            $display("FAIL load_stall got %b want 111", {StallF, StallD, FlushE});
        else pass_cnt++;
        total_cnt++;
        if ({FlushD, StallE} !== 2'b00) $display("FAIL load_nodflush got %b want 00", {FlushD, StallE});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if (CntLoad !== 32'd3) $display("FAIL load_count got %0d want 3", CntLoad);
        else pass_cnt++;
        enableD = 0;
        #1;
        total_cnt++;
        if (StallD !== 1'b0) $display("FAIL load_enabled got %b want 0", StallD);
        else pass_cnt++;
    endtask

    task automatic test_ecall();
        apply_reset();
        EcallM = 2'b10; Rs1D[9:5] = 5'd10; enableD = 1;
        #1;
        total_cnt++;
        if ({StallF, FlushE, FlushD} !== 3'b110)
            $display("FAIL ecall_stall got %b want 110", {StallF, FlushE, FlushD});
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (CntEcall !== 32'd1) $display("FAIL ecall_count got %0d want 1", CntEcall);
        else pass_cnt++;
        enableD = 0;
        #1;
        total_cnt++;
        if (StallF !== 1'b0) $display("FAIL ecall_enabled got %b want 0", StallF);
        else pass_cnt++;
    endtask

    task automatic test_long();
        apply_reset();
        LongE = 2'b01; RdE[4:0] = 5'd9; LongLatE[3:0] = 4'd3;
        @(negedge clk);
        LongE = '0; RdE = '0; enableD = 1; Rs1D[4:0] = 5'd9;
        for (int c = 0; c < 4; c++) begin
            #1;
            total_cnt++;
            if (StallD !== (c < 3)) $display("FAIL long_busy_c%0d got %b want %b", c, StallD, c < 3);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (CntLong !== 32'd3) $display("FAIL long_count got %0d want 3", CntLong);
        else pass_cnt++;
    endtask

    task automatic test_long_miss();
        logic [5:0] miss_pat;
        miss_pat = 6'b000110;
        apply_reset();
        LongE = 2'b01; RdE[4:0] = 5'd9; LongLatE[3:0] = 4'd3;
        @(negedge clk);
        LongE = '0; RdE = '0; enableD = 1; Rs1D[4:0] = 5'd9;
        for (int k = 0; k < 6; k++) begin
            StallMiss = {1'b0, miss_pat[k]};
            #1;
            total_cnt++;
            if ({StallD, StallE, StallW, FlushE} !== {k < 5, miss_pat[k], miss_pat[k], !miss_pat[k] && k < 5})
                $display("FAIL miss_k%0d got %b want %b", k, {StallD, StallE, StallW, FlushE},
                         {k < 5, miss_pat[k], miss_pat[k], !miss_pat[k] && k < 5});
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if (CntLong !== 32'd5) $display("FAIL miss_busy_cycles got %0d want 5", CntLong);
        else pass_cnt++;
        total_cnt++;
        if (CntMiss !== 32'd2) $display("FAIL miss_count got %0d want 2", CntMiss);
        else pass_cnt++;
    endtask

    task automatic test_branch_kill();
        apply_reset();
        PCSrcE = 2'b01; LongE = 2'b10; RdE[9:5] = 5'd4; LongLatE[7:4] = 4'd5;
        #1;
        total_cnt++;
        if ({FlushD, FlushE} !== 2'b11) $display("FAIL br_flush got %b want 11", {FlushD, FlushE});
        else pass_cnt++;
        @(negedge clk);
        PCSrcE = '0; LongE = '0; RdE = '0; enableD = 1; Rs1D[4:0] = 5'd4;
        #1;
        total_cnt++;
        if (StallD !== 1'b0) $display("FAIL br_killed_busy got %b want 0", StallD);
        else pass_cnt++;
        total_cnt++;
        if (CntFlush !== 32'd1) $display("FAIL br_cntflush got %0d want 1", CntFlush);
        else pass_cnt++;
        apply_reset();
        PCSrcE = 2'b10; LongE = 2'b10; RdE[9:5] = 5'd4; LongLatE[7:4] = 4'd5;
        @(negedge clk);
        PCSrcE = '0; LongE = '0; RdE = '0; enableD = 1; Rs1D[4:0] = 5'd4;
        #1;
        total_cnt++;
        if (StallD !== 1'b1) $display("FAIL br_own_lane_busy got %b want 1", StallD);
        else pass_cnt++;
    endtask

    task automatic test_saturate();
        apply_reset();
        StallMiss = 2'b01;
        repeat (10) @(negedge clk);
        #1;
        total_cnt++;
        if (s_cm !== 3'd7) $display("FAIL sat_small got %0d want 7", s_cm);
        else pass_cnt++;
        total_cnt++;
        if (CntMiss !== 32'd10) $display("FAIL sat_wide got %0d want 10", CntMiss);
        else pass_cnt++;
        StallMiss = '0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        LongE = 2'b01; RdE[4:0] = 5'd9; LongLatE[3:0] = 4'd9;
        @(negedge clk);
        LongE = '0; RdE = '0; enableD = 1; Rs1D[4:0] = 5'd9;
        repeat (2) @(negedge clk);
        total_cnt++;
        if (CntLong !== 32'd2) $display("FAIL mid_pre got %0d want 2", CntLong);
        else pass_cnt++;
        #2 reset = 1'b0;
        #1;
        total_cnt++;
        if ({StallD, FlushE} !== 2'b00) $display("FAIL mid_busy_clr got %b want 00", {StallD, FlushE});
        else pass_cnt++;
        total_cnt++;
        if (CntLong !== 32'd0) $display("FAIL mid_cnt_clr got %0d want 0", CntLong);
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (StallD !== 1'b0) $display("FAIL mid_stays_clr got %b want 0", StallD);
        else pass_cnt++;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        test_reset();
        test_forward();
        test_load();
        test_ecall();
        test_long();
        test_long_miss();
        test_branch_kill();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
